read_buffer: RTL and testbench

- Line-to-element unpacker that sits between the AXI-style 512-bit read-data channel and a narrow FIFO in the PageRank engine.
- Captures one returned memory line, then emits a contiguous range of WIDTH-bit lanes from that line, one per cycle, under downstream flow control.
- One instance per stream: vertex pairs (WIDTH=128) and in-edge IDs (WIDTH=64).

---
 rtl/read_buffer.sv | 64 ++++++
 tb/tb_read_buffer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/read_buffer.sv
// Line-to-element unpacker: captures one FULL_WIDTH memory line and emits
// lanes [base, min(bounds, N)) one per cycle under downstream flow control.
module read_buffer #(
  parameter int unsigned FULL_WIDTH = 512,
  parameter int unsigned WIDTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rready,
  input  logic [FULL_WIDTH-1:0] rdata,
  input  logic                  odata_req,
  input  logic [7:0]            base,
  input  logic [7:0]            bounds,
  output logic                  oready,
  output logic [WIDTH-1:0]      odata
);

  localparam int unsigned N = FULL_WIDTH / WIDTH;
  localparam logic [7:0] N_LANES = 8'(N);

  logic                  busy;
  logic [FULL_WIDTH-1:0] line;
  logic [7:0]            idx;
  logic [7:0]            end_idx;
  logic [7:0]            bounds_clamped;
  logic [WIDTH-1:0]      lane_sel;
  logic [7:0]            idx_next;

  assign bounds_clamped = (bounds > N_LANES) ? N_LANES : bounds;
  assign idx_next       = idx + 8'd1;

  // Explicit lane mux keeps the selection in range even if idx were stale.
  always_comb begin
    lane_sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx == 8'(i)) lane_sel = line[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      line    <= '0;
      idx     <= '0;
      end_idx <= '0;
      oready  <= 1'b0;
      odata   <= '0;
    end else if (rready) begin
      line    <= rdata;
      idx     <= base;
      end_idx <= bounds_clamped;
      busy    <= (base < bounds_clamped);
      oready  <= 1'b0;
    end else if (busy && odata_req) begin
      odata  <= lane_sel;
      oready <= 1'b1;
      idx    <= idx_next;
      if (idx_next == end_idx) busy <= 1'b0;
    end else begin
      oready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_read_buffer.sv
// Scoreboard bench: both stream widths share stimulus; a lane-list model fills
// per-instance queues on each load and negedge monitors pop on every oready.
module tb_read_buffer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rready = 1'b0;
  logic [511:0] rdata = '0;
  logic         odata_req = 1'b0;
  logic [7:0]   base = '0;
  logic [7:0]   bounds = '0;
  logic         o64, o128;
  logic [63:0]  d64;
  logic [127:0] d128;

  logic         req_q = 1'b0;
  logic         rready_q = 1'b0;

  logic [63:0]  q64[$];
  logic [127:0] q128[$];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  read_buffer #(.FULL_WIDTH(512), .WIDTH(64)) u64 (
    .clk(clk), .rst(rst), .rready(rready), .rdata(rdata),
    .odata_req(odata_req), .base(base), .bounds(bounds),
    .oready(o64), .odata(d64)
  );

  read_buffer #(.FULL_WIDTH(512), .WIDTH(128)) u128 (
    .clk(clk), .rst(rst), .rready(rready), .rdata(rdata),
    .odata_req(odata_req), .base(base), .bounds(bounds),
    .oready(o128), .odata(d128)
  );

  always @(posedge clk) begin
    req_q    <= odata_req;
    rready_q <= rready;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a load emits lanes base .. min(bounds,N)-1 in order; anything
  // not yet emitted from a previous line is dropped.
  task automatic model_load(input logic [511:0] d, input logic [7:0] b, input logic [7:0] e);
    int unsigned lim;
    q64.delete();
    q128.delete();
    lim = (e > 8) ? 8 : int'(e);
    for (int unsigned i = b; i < lim; i++) q64.push_back(d[i*64 +: 64]);
    lim = (e > 4) ? 4 : int'(e);
    for (int unsigned i = b; i < lim; i++) q128.push_back(d[i*128 +: 128]);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (o64) begin
        chk("gate64", {126'd0, req_q, rready_q}, 128'd2);
        if (q64.size() == 0) chk("unexpected64", 128'd1, 128'd0);
        else chk("data64", {64'd0, d64}, {64'd0, q64.pop_front()});
      end
      if (o128) begin
        chk("gate128", {126'd0, req_q, rready_q}, 128'd2);
        if (q128.size() == 0) chk("unexpected128", 128'd1, 128'd0);
        else chk("data128", d128, q128.pop_front());
      end
    end
  end

  task automatic drive(input bit ld, input logic [511:0] d, input logic [7:0] b,
                       input logic [7:0] e, input bit req);
    rready = ld; rdata = d; base = b; bounds = e; odata_req = req;
    @(posedge clk);
    if (ld) model_load(d, b, e);
    #1;
    rready = 1'b0;
  endtask

  task automatic idle(input bit req);
    drive(1'b0, rdata, base, bounds, req);
  endtask

  task automatic drain(input string name);
    int unsigned n = 0;
    while ((q64.size() != 0 || q128.size() != 0) && n < 40) begin
      idle(1'b1);
      n++;
    end
    idle(1'b1);
    @(negedge clk); #1;
    chk({name, "_q64_empty"}, 128'(q64.size()), 128'd0);
    chk({name, "_q128_empty"}, 128'(q128.size()), 128'd0);
    chk({name, "_idle"}, {126'd0, o64, o128}, 128'd0);
  endtask

  logic [511:0] line_a;
  logic [511:0] line_b;
  logic [511:0] rnd;
  bit           bp_pat [7] = '{1, 0, 0, 1, 1, 0, 1};

  initial begin
    for (int i = 0; i < 8; i++) line_a[i*64 +: 64] = 64'(8'h10 + i);
    for (int i = 0; i < 4; i++) line_b[i*128 +: 128] = {64'(8'hA0 + i), 64'(8'hB0 + i)};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_oready", {126'd0, o64, o128}, 128'd0);
    chk("rst_odata64", {64'd0, d64}, 128'd0);
    chk("rst_odata128", d128, 128'd0);
    rst = 1'b0;
    idle(1'b1);

    // Full line with latency and back-to-back check on the 64-bit stream
    drive(1'b1, line_a, 8'd0, 8'd8, 1'b1);
    @(negedge clk);
    chk("load_edge_oready", {127'd0, o64}, 128'd0);
    for (int i = 0; i < 8; i++) begin
      idle(1'b1);
      @(negedge clk);
      chk("full_consecutive", {127'd0, o64}, 128'd1);
    end
    drain("full");

    drive(1'b1, line_a, 8'd3, 8'd6, 1'b1);
    drain("subrange");

    drive(1'b1, line_a, 8'd0, 8'd4, 1'b1);
    foreach (bp_pat[i]) idle(bp_pat[i]);
    @(negedge clk); #1;
    chk("bp_count64", 128'(q64.size()), 128'd0);
    chk("bp_count128", 128'(q128.size()), 128'd0);
    drain("bp");

    drive(1'b1, line_a, 8'd0, 8'd12, 1'b1);
    drain("clamp");

    drive(1'b1, line_a, 8'd5, 8'd5, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      @(negedge clk);
      chk("empty_no_pulse", {126'd0, o64, o128}, 128'd0);
    end
    drain("empty");

    // Reset after two elements have gone out
    drive(1'b1, line_a, 8'd0, 8'd8, 1'b1);
    idle(1'b1);
    idle(1'b1);
    @(negedge clk); #2;
    chk("pre_rst_left", 128'(q64.size()), 128'd6);
    rst = 1'b1;
    #1;
    chk("async_rst_oready", {126'd0, o64, o128}, 128'd0);
    chk("async_rst_odata64", {64'd0, d64}, 128'd0);
    chk("async_rst_odata128", d128, 128'd0);
    q64.delete();
    q128.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idle(1'b1);
      @(negedge clk);
      chk("post_rst_quiet", {126'd0, o64, o128}, 128'd0);
    end

    drive(1'b1, line_b, 8'd0, 8'd4, 1'b1);
    drain("wide");

    for (int c = 0; c < 400; c++) begin
      for (int w = 0; w < 16; w++) rnd[w*32 +: 32] = $urandom;
      drive($urandom_range(0, 7) == 0, rnd, 8'($urandom_range(0, 9)),
            8'($urandom_range(0, 12)), $urandom_range(0, 3) != 0);
    end
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
